// File: rtl/btn_debounce_pkg.sv
// Shared helpers for the push-button conditioning block.
// Derives the tick divider and its counter width from the clock rates.
package btn_debounce_pkg;

  function automatic int calc_div(input int clk_freq, input int sample_hz);
    return clk_freq / sample_hz;
  endfunction

  function automatic int calc_cw(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_tick_gen.sv
// Shared sample-tick generator for the button debouncer.
// Counts 0..DIV-1 and flags the last count for one clk.
module tick_gen
  import btn_debounce_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SAMPLE_HZ = 1_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ, SAMPLE_HZ);
  localparam int CW  = calc_cw(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/btn_debounce.sv
// Synchronise, sample and debounce raw push buttons.
// Gives a clean level and a one-clk pulse per debounced press.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int NUM_BTN   = 2,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SAMPLE_HZ = 1_000,
  parameter int SAMPLES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_pulse
);

  logic tick;

  tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic               s1_q, s2_q;
    logic [SAMPLES-1:0] sreg_q, sreg_d;
    logic               lvl_q, lvl_d;
    logic               lvl_dly_q, pulse_q;

    // Level only moves on a full run of equal samples.
    always_comb begin
      sreg_d = sreg_q;
      lvl_d  = lvl_q;
      if (tick) begin
        sreg_d = {sreg_q[SAMPLES-2:0], s2_q};
        if (&sreg_d)       lvl_d = 1'b1;
        else if (~|sreg_d) lvl_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        sreg_q    <= '0;
        lvl_q     <= 1'b0;
        lvl_dly_q <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        s1_q      <= i_btn[i];
        s2_q      <= s1_q;
        sreg_q    <= sreg_d;
        lvl_q     <= lvl_d;
        lvl_dly_q <= lvl_q;
        pulse_q   <= lvl_q & ~lvl_dly_q;
      end
    end

    assign o_level[i] = lvl_q;
    assign o_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce.
// DIV=10, SAMPLES=4, two channels.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_btn = 2'b11;
  logic [1:0] o_level;
  logic [1:0] o_pulse;

  int total = 0;
  int bad = 0;
  int pc0 = 0;
  int pc1 = 0;
  int base0, base1, cyc;
  logic seen;

  btn_debounce #(
    .NUM_BTN   (2),
    .CLK_FREQ  (1000),
    .SAMPLE_HZ (100),
    .SAMPLES   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (i_btn),
    .o_level (o_level),
    .o_pulse (o_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_pulse[0]) pc0 = pc0 + 1;
    if (o_pulse[1]) pc1 = pc1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input int ch, input logic val,
                            input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n = n + 1;
    end while (o_level[ch] !== val && n < maxc);
  endtask

  initial begin
    // 1: reset held with both buttons pressed
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("rst_level", 32'(o_level), 32'd0);
      chk("rst_pulse", 32'(o_pulse), 32'd0);
      chk("rst_cnt", 32'(dut.u_tick.cnt_q), 32'd0);
    end

    // 2: clean press on ch0, rise at clk 40
    rst = 1'b0;
    i_btn = 2'b01;
    base0 = pc0;
    base1 = pc1;
    wait_level(0, 1'b1, 60, cyc);
    chk("press_latency", 32'(cyc), 32'd40);
    chk("press_nopulse_yet", 32'(o_pulse[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("press_pulse_hi", 32'(o_pulse[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("press_pulse_lo", 32'(o_pulse[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("press_pulse_cnt", 32'(pc0 - base0), 32'd1);
    chk("press_ch1_level", 32'(o_level[1]), 32'd0);
    chk("press_ch1_pulse", 32'(pc1 - base1), 32'd0);

    // 3: bouncing press on ch1
    base0 = pc0;
    base1 = pc1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k % 3 == 0) i_btn[1] = ~i_btn[1];
      @(posedge clk);
      #1;
      if (o_level[1]) seen = 1'b1;
    end
    chk("bounce_no_level", 32'(seen), 32'd0);
    chk("bounce_no_pulse", 32'(pc1 - base1), 32'd0);
    i_btn[1] = 1'b1;
    wait_level(1, 1'b1, 60, cyc);
    chk("bounce_rise_bound", 32'(cyc <= 42), 32'd1);
    chk("bounce_level", 32'(o_level[1]), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bounce_pulse_cnt", 32'(pc1 - base1), 32'd1);
    chk("bounce_ch0_quiet", 32'(pc0 - base0), 32'd0);
    chk("bounce_ch0_level", 32'(o_level[0]), 32'd1);

    // 5: release ch0
    base0 = pc0;
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 60, cyc);
    chk("release_bound", 32'(cyc <= 42), 32'd1);
    chk("release_level", 32'(o_level[0]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("release_no_pulse", 32'(pc0 - base0), 32'd0);

    // 4: 2-clk glitch on ch0
    base0 = pc0;
    repeat (4) @(posedge clk);
    #1;
    i_btn[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_btn[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (o_level[0]) seen = 1'b1;
    end
    chk("glitch_no_level", 32'(seen), 32'd0);
    chk("glitch_no_pulse", 32'(pc0 - base0), 32'd0);

    // 6: reset after two high samples discards history
    i_btn = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_btn = 2'b01;
    repeat (25) @(posedge clk);
    #1;
    chk("mid_sreg", 32'(dut.g_ch[0].sreg_q), 32'h3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_level", 32'(o_level), 32'd0);
    chk("mid_rst_sreg", 32'(dut.g_ch[0].sreg_q), 32'd0);
    chk("mid_rst_cnt", 32'(dut.u_tick.cnt_q), 32'd0);
    rst = 1'b0;
    base0 = pc0;
    wait_level(0, 1'b1, 60, cyc);
    chk("mid_requal", 32'(cyc), 32'd40);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pulse_cnt", 32'(pc0 - base0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
